// File: rtl/pe_pkg.sv
// Shared state encoding, width helpers and requantization arithmetic for the self-sequenced PE array.
package pe_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COMPUTE = 2'd1;
  localparam logic [1:0] ST_DRAIN   = 2'd2;
  localparam logic [1:0] ST_OUT     = 2'd3;

  function automatic int prod_w(input int dw);
    return 2 * dw;
  endfunction

  function automatic int tree_w(input int dw, input int nc);
    return 2 * dw + $clog2(nc);
  endfunction

  // Round-half-up arithmetic shift; 64 bits leaves headroom for the rounding add.
  function automatic logic signed [63:0] round_shift(input logic signed [63:0] v, input int sh);
    logic signed [63:0] r;
    r = v;
    if (sh > 0) r = r + (64'sd1 <<< (sh - 1));
    return r >>> sh;
  endfunction

  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/pe_row_mac.sv
// One output row: registered channel products, adder tree into a signed accumulator,
// and combinational requantization (round-shift, optional ReLU, saturate) of the accumulator.
module pe_row_mac
  import pe_pkg::*;
#(
  parameter int DW    = 8,
  parameter int NC    = 8,
  parameter int ACC_W = 24,
  parameter int SB    = 5
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic [NC*DW-1:0] iact_dat,
  input  logic [NC*DW-1:0] wght_dat,
  input  logic             acc_clr,
  input  logic             acc_en,
  input  logic [SB-1:0]    shift,
  input  logic             relu,
  output logic [DW-1:0]    oact
);

  localparam int PW = prod_w(DW);
  localparam int TW = tree_w(DW, NC);

  logic signed [PW-1:0]    prod_q [NC];
  logic signed [PW-1:0]    prod_d [NC];
  logic signed [TW-1:0]    tree_sum;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [63:0]      rq;

  always_comb begin
    for (int c = 0; c < NC; c++) begin
      prod_d[c] = PW'($signed(iact_dat[c*DW +: DW])) * PW'($signed(wght_dat[c*DW +: DW]));
    end
  end

  always_comb begin
    tree_sum = '0;
    for (int c = 0; c < NC; c++) begin
      tree_sum = tree_sum + TW'(prod_q[c]);
    end
    acc_d = acc_q;
    if (acc_clr)     acc_d = '0;
    else if (acc_en) acc_d = acc_q + ACC_W'(tree_sum);
  end

  always_comb begin
    rq = round_shift(64'(acc_q), int'(shift));
    if (relu && rq < 0) rq = '0;
    rq   = sat(rq, DW);
    oact = rq[DW-1:0];
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int c = 0; c < NC; c++) prod_q[c] <= '0;
      acc_q <= '0;
    end else begin
      for (int c = 0; c < NC; c++) prod_q[c] <= prod_d[c];
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/pe_array_seq.sv
// Self-sequenced PE array: tap regfiles loaded in IDLE, len-tap MAC run, 3-cycle drain,
// requantized oact vector held under valid/ready until accepted.
module pe_array_seq
  import pe_pkg::*;
#(
  parameter int DATA_BITWIDTH  = 8,
  parameter int ACC_BITWIDTH   = 24,
  parameter int NUM_OF_CHANNEL = 8,
  parameter int NUM_OF_WEIGHT  = 8,
  parameter int DEPTH_BITWIDTH = 4,
  parameter int SHIFT_BITWIDTH = 5
) (
  input  logic                                                   clk,
  input  logic                                                   rstN,
  input  logic                                                   wght_valid,
  output logic                                                   wght_ready,
  input  logic [DEPTH_BITWIDTH-1:0]                              wght_addr,
  input  logic [NUM_OF_WEIGHT*NUM_OF_CHANNEL*DATA_BITWIDTH-1:0]  wght_data,
  input  logic                                                   iact_valid,
  output logic                                                   iact_ready,
  input  logic [DEPTH_BITWIDTH-1:0]                              iact_addr,
  input  logic [NUM_OF_CHANNEL*DATA_BITWIDTH-1:0]                iact_data,
  input  logic                                                   start,
  input  logic [DEPTH_BITWIDTH:0]                                cfg_len,
  input  logic [SHIFT_BITWIDTH-1:0]                              cfg_shift,
  input  logic                                                   cfg_relu,
  output logic                                                   busy,
  output logic                                                   oact_valid,
  input  logic                                                   oact_ready,
  output logic [NUM_OF_WEIGHT*DATA_BITWIDTH-1:0]                 oacts
);

  localparam int DW    = DATA_BITWIDTH;
  localparam int NC    = NUM_OF_CHANNEL;
  localparam int NW    = NUM_OF_WEIGHT;
  localparam int D     = DEPTH_BITWIDTH;
  localparam int SB    = SHIFT_BITWIDTH;
  localparam int DEPTH = 1 << D;
  localparam logic [D:0] MAX_LEN = {1'b1, {D{1'b0}}};
  localparam logic [D:0] LEN_ONE = {{D{1'b0}}, 1'b1};

  logic [1:0]          state_q, state_d;
  logic [D:0]          len_q, len_d;
  logic [D:0]          cnt_q, cnt_d;
  logic [1:0]          drn_q, drn_d;
  logic [SB-1:0]       shift_q, shift_d;
  logic                relu_q, relu_d;
  logic                rd_vld_q, rd_vld_d;
  logic                prod_vld_q, prod_vld_d;
  logic                acc_clr;
  logic [NC*DW-1:0]    iact_rd_q, iact_rd_d;
  logic [NW*NC*DW-1:0] wght_rd_q, wght_rd_d;
  logic [NW*DW-1:0]    oacts_q, oacts_d, rq_oacts;
  logic                oact_valid_q, oact_valid_d;
  logic                idle;

  logic [NC*DW-1:0]    iact_rf [DEPTH];
  logic [NW*NC*DW-1:0] wght_rf [DEPTH];

  assign idle       = (state_q == ST_IDLE);
  assign wght_ready = idle;
  assign iact_ready = idle;
  assign busy       = !idle;
  assign oact_valid = oact_valid_q;
  assign oacts      = oacts_q;

  // Regfiles carry no reset; a write coinciding with start lands before the first read.
  always_ff @(posedge clk) begin
    if (iact_valid && idle) iact_rf[iact_addr] <= iact_data;
    if (wght_valid && idle) wght_rf[wght_addr] <= wght_data;
  end

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    drn_d        = drn_q;
    shift_d      = shift_q;
    relu_d       = relu_q;
    oacts_d      = oacts_q;
    oact_valid_d = oact_valid_q;
    rd_vld_d     = 1'b0;
    prod_vld_d   = rd_vld_q;
    acc_clr      = 1'b0;
    iact_rd_d    = iact_rf[cnt_q[D-1:0]];
    wght_rd_d    = wght_rf[cnt_q[D-1:0]];
    case (state_q)
      ST_IDLE: begin
        if (start && cfg_len != '0) begin
          len_d   = (cfg_len > MAX_LEN) ? MAX_LEN : cfg_len;
          shift_d = cfg_shift;
          relu_d  = cfg_relu;
          cnt_d   = '0;
          acc_clr = 1'b1;
          state_d = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        rd_vld_d = 1'b1;
        cnt_d    = cnt_q + LEN_ONE;
        if (cnt_q == len_q - LEN_ONE) begin
          drn_d   = 2'd0;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Third drain cycle: the last tap has just reached the accumulators.
        drn_d = drn_q + 2'd1;
        if (drn_q == 2'd2) begin
          oacts_d      = rq_oacts;
          oact_valid_d = 1'b1;
          state_d      = ST_OUT;
        end
      end
      default: begin
        if (oact_ready) begin
          oact_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      cnt_q        <= '0;
      drn_q        <= '0;
      shift_q      <= '0;
      relu_q       <= 1'b0;
      rd_vld_q     <= 1'b0;
      prod_vld_q   <= 1'b0;
      iact_rd_q    <= '0;
      wght_rd_q    <= '0;
      oacts_q      <= '0;
      oact_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      drn_q        <= drn_d;
      shift_q      <= shift_d;
      relu_q       <= relu_d;
      rd_vld_q     <= rd_vld_d;
      prod_vld_q   <= prod_vld_d;
      iact_rd_q    <= iact_rd_d;
      wght_rd_q    <= wght_rd_d;
      oacts_q      <= oacts_d;
      oact_valid_q <= oact_valid_d;
    end
  end

  for (genvar w = 0; w < NW; w++) begin : g_row
    pe_row_mac #(
      .DW   (DW),
      .NC   (NC),
      .ACC_W(ACC_BITWIDTH),
      .SB   (SB)
    ) u_row (
      .clk     (clk),
      .rstN    (rstN),
      .iact_dat(iact_rd_q),
      .wght_dat(wght_rd_q[w*NC*DW +: NC*DW]),
      .acc_clr (acc_clr),
      .acc_en  (prod_vld_q),
      .shift   (shift_q),
      .relu    (relu_q),
      .oact    (rq_oacts[w*DW +: DW])
    );
  end

endmodule
